// File: rtl/fpaddsub_round_pipe_pkg.sv
// Shared definitions for the FP add/sub rounding pipeline: rounding-mode encodings
// and bit positions inside the exception flag vector.
package fpaddsub_round_pipe_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  localparam int FLAG_W   = 5;
  localparam int FLAG_INX = 0;
  localparam int FLAG_INV = 1;
  localparam int FLAG_DBZ = 2;
  localparam int FLAG_UNF = 3;
  localparam int FLAG_OVF = 4;

endpackage

// File: rtl/fpaddsub_round_decide.sv
// Rounding increment decision from mode, sign, LSB, round and sticky bits.
// Kept separate so the multiplier round stage can share it.
module fpaddsub_round_decide
  import fpaddsub_round_pipe_pkg::*;
(
  input  logic [1:0] rmode,
  input  logic       sgn,
  input  logic       lsb,
  input  logic       rnd,
  input  logic       sticky,
  output logic       inc
);

  always_comb begin
    inc = 1'b0;
    case (rmode_e'(rmode))
      RM_RNE:  inc = rnd & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sgn & (rnd | sticky);
      RM_RDN:  inc = sgn & (rnd | sticky);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpaddsub_round_pipe.sv
// Final FP add/sub stage: rounds the normalised mantissa, then selects the packed
// IEEE-754 result and exception flags, over a two-stage valid/ready pipeline.
module fpaddsub_round_pipe
  import fpaddsub_round_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               RMode,
  input  logic                     ZeroSum,
  input  logic                     Sgn,
  input  logic                     Sa,
  input  logic                     Sb,
  input  logic                     Ctrl,
  input  logic                     NegE,
  input  logic [EXP_W:0]           NormE,
  input  logic [MAN_W-1:0]         NormM,
  input  logic                     R,
  input  logic                     S,
  input  logic                     ExcNaN,
  input  logic                     ExcInf,
  input  logic                     ExcInv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     Z,
  output logic [FLAG_W-1:0]        Flags
);

  // Overflowed results become infinity only when the mode rounds away from zero.
  function automatic logic ovf_to_inf(input rmode_e rm, input logic sgn);
    return (rm == RM_RNE) | ((rm == RM_RUP) & ~sgn) | ((rm == RM_RDN) & sgn);
  endfunction

  function automatic logic zero_sign(input rmode_e rm, input logic sa, input logic sb,
                                     input logic ctrl);
    return (sa == (sb ^ ctrl)) ? sa : (rm == RM_RDN);
  endfunction

  logic en;
  logic inc;
  logic [MAN_W:0] sum_m;
  logic [EXP_W:0] round_e;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  fpaddsub_round_decide u_decide (
    .rmode  (RMode),
    .sgn    (Sgn),
    .lsb    (NormM[0]),
    .rnd    (R),
    .sticky (S),
    .inc    (inc)
  );

  // A carry out leaves the low mantissa bits at zero, so only the exponent needs it.
  assign sum_m   = {1'b0, NormM} + {{MAN_W{1'b0}}, inc};
  assign round_e = NormE + {{EXP_W{1'b0}}, sum_m[MAN_W]};

  // ---- stage 1: rounded mantissa/exponent and transaction context ----
  logic             vld_p1;
  rmode_e           rmode_p1;
  logic             zero_p1, sgn_p1, sa_p1, sb_p1, ctrl_p1, nege_p1;
  logic             nan_p1, inf_p1, inv_p1, inx_p1;
  logic [MAN_W-1:0] man_p1;
  logic [EXP_W:0]   exp_p1;

  always_ff @(posedge CLK) begin
    if (RST)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= in_valid;
  end

  always_ff @(posedge CLK) begin
    if (en) begin
      rmode_p1 <= rmode_e'(RMode);
      zero_p1  <= ZeroSum;
      sgn_p1   <= Sgn;
      sa_p1    <= Sa;
      sb_p1    <= Sb;
      ctrl_p1  <= Ctrl;
      nege_p1  <= NegE;
      nan_p1   <= ExcNaN;
      inf_p1   <= ExcInf;
      inv_p1   <= ExcInv;
      inx_p1   <= R | S;
      man_p1   <= sum_m[MAN_W-1:0];
      exp_p1   <= round_e;
    end
  end

  // ---- stage 2: result select and flags ----
  logic [EXP_W+MAN_W:0] z_c;
  logic [FLAG_W-1:0]    flags_c;
  logic                 ovf;

  assign ovf = exp_p1[EXP_W] | (&exp_p1[EXP_W-1:0]);

  always_comb begin
    z_c     = {sgn_p1, exp_p1[EXP_W-1:0], man_p1};
    flags_c = '0;
    flags_c[FLAG_INX] = inx_p1;
    if (nan_p1) begin
      z_c     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_c = '0;
      flags_c[FLAG_INV] = inv_p1;
    end else if (inf_p1) begin
      z_c     = {sgn_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = '0;
      flags_c[FLAG_INV] = inv_p1;
    end else if (zero_p1) begin
      z_c     = {zero_sign(rmode_p1, sa_p1, sb_p1, ctrl_p1), {(EXP_W+MAN_W){1'b0}}};
      flags_c = '0;
    end else if (nege_p1) begin
      z_c     = {sgn_p1, {(EXP_W+MAN_W){1'b0}}};
      flags_c = '0;
      flags_c[FLAG_UNF] = 1'b1;
      flags_c[FLAG_INX] = 1'b1;
    end else if (ovf) begin
      if (ovf_to_inf(rmode_p1, sgn_p1))
        z_c = {sgn_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
        z_c = {sgn_p1, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
      flags_c = '0;
      flags_c[FLAG_OVF] = 1'b1;
      flags_c[FLAG_INX] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      Z         <= '0;
      Flags     <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      Z         <= z_c;
      Flags     <= flags_c;
    end
  end

endmodule

// File: tb/tb_fpaddsub_round_pipe.sv
// Directed bench for fpaddsub_round_pipe with a queue scoreboard of expected results.
module tb_fpaddsub_round_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  RMode;
  logic        ZeroSum, Sgn, Sa, Sb, Ctrl, NegE, R, S, ExcNaN, ExcInf, ExcInv;
  logic [8:0]  NormE;
  logic [22:0] NormM;
  logic [31:0] Z;
  logic [4:0]  Flags;

  always #5 CLK = ~CLK;

  fpaddsub_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .RMode(RMode), .ZeroSum(ZeroSum), .Sgn(Sgn), .Sa(Sa), .Sb(Sb), .Ctrl(Ctrl),
    .NegE(NegE), .NormE(NormE), .NormM(NormM), .R(R), .S(S),
    .ExcNaN(ExcNaN), .ExcInf(ExcInf), .ExcInv(ExcInv),
    .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .Flags(Flags)
  );

  typedef struct {
    logic [1:0]  rm;
    logic        zs, sgn, sa, sb, ctrl, nege, r, s, nan, inf, inv;
    logic [8:0]  e;
    logic [22:0] m;
    logic [31:0] z;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rm, input logic [8:0] e, input logic [22:0] m,
                              input logic r, input logic s, input logic sgn,
                              input logic [31:0] z, input logic [4:0] f);
    vec_t v;
    v.rm = rm; v.e = e; v.m = m; v.r = r; v.s = s; v.sgn = sgn; v.z = z; v.f = f;
    v.zs = 1'b0; v.sa = 1'b0; v.sb = 1'b0; v.ctrl = 1'b0; v.nege = 1'b0;
    v.nan = 1'b0; v.inf = 1'b0; v.inv = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    cur = v;
    RMode = v.rm; ZeroSum = v.zs; Sgn = v.sgn; Sa = v.sa; Sb = v.sb; Ctrl = v.ctrl;
    NegE = v.nege; NormE = v.e; NormM = v.m; R = v.r; S = v.s;
    ExcNaN = v.nan; ExcInf = v.inf; ExcInv = v.inv;
    in_valid = 1'b1;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send(input vec_t v);
    apply(v);
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL accept_timeout observed no in_ready expected acceptance");
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_output observed Z=%h expected no output", Z);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("Z", Z, e.z);
          chk("Flags", {27'b0, Flags}, {27'b0, e.f});
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{cur.z, cur.f});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t h[4];
    int   base;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    apply(mk(2'b00, 9'h0, 23'h0, 0, 0, 0, 32'h0, 5'h0));
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_Z", Z, 32'h0);
    chk("rst_Flags", {27'b0, Flags}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Tie to even, with latency check.
    send(mk(2'b00, 9'h080, 23'h000001, 1, 0, 0, 32'h40000002, 5'b00001));
    in_valid = 1'b0;
    @(negedge CLK);
    chk("latency_not_early", {31'b0, out_valid}, 32'h0);
    @(negedge CLK);
    chk("latency_2", {31'b0, out_valid}, 32'h1);
    @(posedge CLK);
    #1;

    // Back-to-back directed cases.
    send(mk(2'b00, 9'h07F, 23'h7FFFFF, 1, 1, 0, 32'h40000000, 5'b00001));
    send(mk(2'b00, 9'h0FF, 23'h0, 0, 0, 0, 32'h7F800000, 5'b10001));
    send(mk(2'b01, 9'h0FF, 23'h0, 0, 0, 0, 32'h7F7FFFFF, 5'b10001));
    send(mk(2'b11, 9'h0FF, 23'h0, 0, 0, 0, 32'h7F7FFFFF, 5'b10001));
    send(mk(2'b10, 9'h0FF, 23'h0, 0, 0, 0, 32'h7F800000, 5'b10001));
    send(mk(2'b11, 9'h100, 23'h0, 0, 0, 1, 32'hFF800000, 5'b10001));
    send(mk(2'b10, 9'h080, 23'h0, 0, 1, 0, 32'h40000001, 5'b00001));
    send(mk(2'b11, 9'h080, 23'h0, 0, 1, 1, 32'hC0000001, 5'b00001));
    send(mk(2'b01, 9'h080, 23'h0, 1, 1, 0, 32'h40000000, 5'b00001));
    send(mk(2'b00, 9'h080, 23'h000002, 1, 0, 0, 32'h40000002, 5'b00001));
    send(mk(2'b00, 9'h080, 23'h123456, 0, 0, 0, 32'h40123456, 5'b00000));
    v = mk(2'b00, 9'h080, 23'h0, 0, 0, 0, 32'h00000000, 5'b00000);
    v.zs = 1; v.ctrl = 1;
    send(v);
    v.rm = 2'b11; v.z = 32'h80000000;
    send(v);
    v = mk(2'b00, 9'h090, 23'h1, 1, 1, 0, 32'h80000000, 5'b00000);
    v.zs = 1; v.sa = 1; v.sb = 1;
    send(v);
    v = mk(2'b00, 9'h080, 23'h0, 0, 0, 0, 32'h7FC00000, 5'b00010);
    v.nan = 1; v.inv = 1; v.inf = 1;
    send(v);
    v = mk(2'b00, 9'h080, 23'h0, 0, 0, 1, 32'hFF800000, 5'b00000);
    v.inf = 1;
    send(v);
    v = mk(2'b00, 9'h080, 23'h0, 0, 0, 1, 32'h80000000, 5'b01001);
    v.nege = 1;
    send(v);
    drain();
    chk("directed_count", n_out, 18);

    // Backpressure: four transactions, output stalled for 5 cycles.
    base = n_out;
    h[0] = mk(2'b00, 9'h081, 23'h000010, 0, 0, 0, 32'h40800010, 5'b00000);
    h[1] = mk(2'b01, 9'h082, 23'h000020, 1, 1, 1, 32'hC1000020, 5'b00001);
    h[2] = mk(2'b10, 9'h083, 23'h000030, 0, 1, 0, 32'h41800031, 5'b00001);
    h[3] = mk(2'b11, 9'h084, 23'h000040, 1, 0, 0, 32'h42000040, 5'b00001);
    out_ready = 1'b0;
    send(h[0]);
    send(h[1]);
    apply(h[2]);
    repeat (5) begin
      @(negedge CLK);
      chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
      chk("stall_Z", Z, h[0].z);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send(h[2]);
    send(h[3]);
    drain();
    chk("handshake_count", n_out - base, 4);

    // Reset with two transactions in flight.
    send(mk(2'b00, 9'h085, 23'h1, 0, 0, 0, 32'h42800001, 5'b00000));
    send(mk(2'b00, 9'h086, 23'h2, 0, 0, 0, 32'h43000002, 5'b00000));
    in_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    base = n_out;
    repeat (4) begin
      @(negedge CLK);
      chk("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
    end
    chk("post_rst_no_output", n_out - base, 0);
    @(posedge CLK);
    #1;
    send(mk(2'b00, 9'h080, 23'h000001, 1, 0, 0, 32'h40000002, 5'b00001));
    drain();
    chk("recover_count", n_out - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
